// File: rtl/axi_tb_pkg.sv
// Shared AXI response codes, master indices and the round-robin pick helper
// used by the DMA port arbiter.
package axi_tb_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int unsigned LSU_M = 0;
  localparam int unsigned TB_M  = 1;

  // Two-way round robin: on a tie the last-granted master loses.
  function automatic logic rr_pick(logic [1:0] req, logic last);
    if (req[0] && req[1]) begin
      return ~last;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/arb_src_fifo.sv
// In-order 1-bit source FIFO: records which master owns each outstanding
// transaction so responses can be steered back without AXI IDs.
module arb_src_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic reset_l,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == (PtrW+1)'(Depth));
    dout_o  = mem_q[rptr_q];
    do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when it is popped in the same cycle.
    do_push = push_i & (~full_o | do_pop);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_dma_port_arb.sv
// Two-master arbiter onto the single-beat AXI DMA slave port; responses are
// routed back through in-order source FIFOs.
module axi_dma_port_arb
  import axi_tb_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 64,
  parameter int unsigned OUTST = 4
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic [1:0]      m_arvalid,
  input  logic [2*AW-1:0] m_araddr,
  output logic [1:0]      m_arready,
  output logic [1:0]      m_rvalid,
  output logic [DW-1:0]   m_rdata,
  output logic [1:0]      m_rresp,
  input  logic [1:0]      m_rready,
  input  logic [1:0]      m_awvalid,
  input  logic [2*AW-1:0] m_awaddr,
  output logic [1:0]      m_awready,
  input  logic [1:0]      m_wvalid,
  input  logic [2*DW-1:0] m_wdata,
  output logic [1:0]      m_wready,
  output logic [1:0]      m_bvalid,
  output logic [1:0]      m_bresp,
  input  logic [1:0]      m_bready,
  output logic            s_arvalid,
  output logic [AW-1:0]   s_araddr,
  input  logic            s_arready,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  output logic            s_rready,
  output logic            s_awvalid,
  output logic [AW-1:0]   s_awaddr,
  input  logic            s_awready,
  output logic            s_wvalid,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_wready,
  input  logic            s_bvalid,
  input  logic [1:0]      s_bresp,
  output logic            s_bready,
  output logic            proto_err
);

  logic ar_lock_q, ar_gnt_q, ar_last_q, ar_gnt, ar_stall;
  logic aw_lock_q, aw_gnt_q, aw_last_q, aw_gnt, aw_stall;
  logic r_head, r_full, r_empty, r_push, r_pop;
  logic w_head, w_full, w_empty, w_pop;
  logic b_head, b_full, b_empty, b_pop;
  logic aw_push, proto_err_q, proto_err_d;

  // Response routing: only the FIFO-head lane sees valid, only it drives ready.
  always_comb begin
    s_rready = ~r_empty & m_rready[r_head];
    r_pop    = s_rvalid & s_rready;
    m_rvalid = '0;
    m_rvalid[r_head] = s_rvalid & ~r_empty;
    m_rdata  = s_rdata;
    m_rresp  = s_rresp;

    s_bready = ~b_empty & m_bready[b_head];
    b_pop    = s_bvalid & s_bready;
    m_bvalid = '0;
    m_bvalid[b_head] = s_bvalid & ~b_empty;
    m_bresp  = s_bresp;

    // W waits until its AW has been forwarded, then follows AW order.
    s_wvalid = m_wvalid[w_head] & ~w_empty;
    s_wdata  = w_head ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0];
    w_pop    = s_wvalid & s_wready;
    m_wready = '0;
    m_wready[w_head] = s_wready & ~w_empty;
  end

  // Address arbiters: a slot freed by a same-cycle pop counts as space.
  always_comb begin
    ar_gnt    = ar_lock_q ? ar_gnt_q : rr_pick(m_arvalid, ar_last_q);
    ar_stall  = r_full & ~r_pop;
    s_arvalid = reset_l & m_arvalid[ar_gnt] & ~ar_stall;
    s_araddr  = ar_gnt ? m_araddr[2*AW-1:AW] : m_araddr[AW-1:0];
    m_arready = '0;
    m_arready[ar_gnt] = reset_l & s_arready & ~ar_stall;
    r_push    = s_arvalid & s_arready;

    aw_gnt    = aw_lock_q ? aw_gnt_q : rr_pick(m_awvalid, aw_last_q);
    aw_stall  = (w_full & ~w_pop) | (b_full & ~b_pop);
    s_awvalid = reset_l & m_awvalid[aw_gnt] & ~aw_stall;
    s_awaddr  = aw_gnt ? m_awaddr[2*AW-1:AW] : m_awaddr[AW-1:0];
    m_awready = '0;
    m_awready[aw_gnt] = reset_l & s_awready & ~aw_stall;
    aw_push   = s_awvalid & s_awready;

    proto_err_d = proto_err_q | (s_rvalid & r_empty) | (s_bvalid & b_empty);
    proto_err   = proto_err_q;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ar_lock_q   <= 1'b0;
      ar_gnt_q    <= 1'(LSU_M);
      ar_last_q   <= 1'(TB_M);
      aw_lock_q   <= 1'b0;
      aw_gnt_q    <= 1'(LSU_M);
      aw_last_q   <= 1'(TB_M);
      proto_err_q <= 1'b0;
    end else begin
      ar_lock_q   <= s_arvalid & ~s_arready;
      ar_gnt_q    <= ar_gnt;
      aw_lock_q   <= s_awvalid & ~s_awready;
      aw_gnt_q    <= aw_gnt;
      proto_err_q <= proto_err_d;
      if (r_push)  ar_last_q <= ar_gnt;
      if (aw_push) aw_last_q <= aw_gnt;
    end
  end

  arb_src_fifo #(.Depth(OUTST)) u_rfifo (
    .clk(clk), .reset_l(reset_l), .push_i(r_push), .din_i(ar_gnt), .pop_i(r_pop),
    .dout_o(r_head), .full_o(r_full), .empty_o(r_empty)
  );

  arb_src_fifo #(.Depth(OUTST)) u_wfifo (
    .clk(clk), .reset_l(reset_l), .push_i(aw_push), .din_i(aw_gnt), .pop_i(w_pop),
    .dout_o(w_head), .full_o(w_full), .empty_o(w_empty)
  );

  arb_src_fifo #(.Depth(OUTST)) u_bfifo (
    .clk(clk), .reset_l(reset_l), .push_i(aw_push), .din_i(aw_gnt), .pop_i(b_pop),
    .dout_o(b_head), .full_o(b_full), .empty_o(b_empty)
  );

endmodule

// File: tb/tb_axi_dma_port_arb.sv
// Directed bench for axi_dma_port_arb: read interleave, outstanding limit,
// AR lock, write ordering, protocol error and asynchronous reset.
module tb_axi_dma_port_arb;
  import axi_tb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset_l;
  logic [1:0] m_arvalid, m_arready, m_rvalid, m_rresp, m_rready;
  logic [2*AW-1:0] m_araddr, m_awaddr;
  logic [DW-1:0] m_rdata;
  logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bresp, m_bready;
  logic [2*DW-1:0] m_wdata;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready, proto_err;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [1:0] s_rresp, s_bresp;

  int checks = 0;
  int errors = 0;

  axi_dma_port_arb dut (
    .clk(clk), .reset_l(reset_l),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] rdat [4];
  logic [1:0]  rlane [4];

  initial begin
    reset_l = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_bready = '0;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = OKAY;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = OKAY;
    #2;
    check("rst_m_arready", 64'(m_arready), 64'h0);
    check("rst_m_awready", 64'(m_awready), 64'h0);
    check("rst_s_arvalid", 64'(s_arvalid), 64'h0);
    check("rst_proto_err", 64'(proto_err), 64'h0);
    @(negedge clk);
    reset_l = 1'b1;

    // Both masters request every cycle: grants alternate starting at master 0.
    m_arvalid = 2'b11;
    m_araddr  = {32'h0000_0200, 32'h0000_0100};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_s_araddr", 64'(s_araddr), (i % 2 == 0) ? 64'h100 : 64'h200);
      check("rr_m_arready", 64'(m_arready), (i % 2 == 0) ? 64'h1 : 64'h2);
      @(negedge clk);
    end
    #1;
    check("full_s_arvalid", 64'(s_arvalid), 64'h0);
    check("full_m_arready", 64'(m_arready), 64'h0);
    @(negedge clk);
    // One R pop frees a slot; the 5th AR (master 0) goes in the same cycle.
    s_rvalid = 1'b1; s_rdata = 64'hA0A0_0000_0000_0000; m_rready = 2'b11;
    #1;
    check("pop_m_rvalid", 64'(m_rvalid), 64'h1);
    check("pop_m_rdata", m_rdata, 64'hA0A0_0000_0000_0000);
    check("pop_s_arvalid", 64'(s_arvalid), 64'h1);
    check("pop_m_arready", 64'(m_arready), 64'h1);
    check("pop_s_araddr", 64'(s_araddr), 64'h100);
    @(negedge clk);
    m_arvalid = 2'b00;
    rdat  = '{64'h1111, 64'h2222, 64'h3333, 64'h4444};
    rlane = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      s_rdata = rdat[i];
      #1;
      check("ret_m_rvalid", 64'(m_rvalid), 64'(rlane[i]));
      check("ret_m_rdata", m_rdata, rdat[i]);
      @(negedge clk);
    end
    s_rvalid = 1'b0;

    // AR held by slave: grant stays on master 0 even after master 1 asks.
    s_arready = 1'b0; m_arvalid = 2'b01;
    m_araddr  = {32'h0000_0400, 32'h0000_0300};
    #1;
    check("lock_s_araddr0", 64'(s_araddr), 64'h300);
    @(negedge clk);
    m_arvalid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lock_s_araddr", 64'(s_araddr), 64'h300);
      check("lock_m_arready", 64'(m_arready), 64'h0);
      @(negedge clk);
    end
    s_arready = 1'b1;
    #1;
    check("lock_hs_araddr", 64'(s_araddr), 64'h300);
    check("lock_hs_arready", 64'(m_arready), 64'h1);
    @(negedge clk);
    m_arvalid = 2'b10;
    #1;
    check("unlock_s_araddr", 64'(s_araddr), 64'h400);
    @(negedge clk);
    m_arvalid = 2'b00;

    // Writes: m1 AW first, m0 AW next; m0's early W must wait for m1's W.
    m_awvalid = 2'b10; m_awaddr = {32'h0000_1000, 32'h0000_2000};
    m_wvalid = 2'b01; m_wdata = {64'hDEAD_BEEF_0000_0001, 64'h5555};
    #1;
    check("w0_s_awaddr", 64'(s_awaddr), 64'h1000);
    check("w0_m_awready", 64'(m_awready), 64'h2);
    check("w0_m_wready", 64'(m_wready), 64'h0);
    check("w0_s_wvalid", 64'(s_wvalid), 64'h0);
    @(negedge clk);
    m_awvalid = 2'b01;
    #1;
    check("w1_s_awaddr", 64'(s_awaddr), 64'h2000);
    check("w1_m_awready", 64'(m_awready), 64'h1);
    check("w1_m_wready", 64'(m_wready), 64'h2);
    check("w1_s_wvalid", 64'(s_wvalid), 64'h0);
    @(negedge clk);
    m_awvalid = 2'b00; m_wvalid = 2'b11;
    #1;
    check("w2_s_wdata", s_wdata, 64'hDEAD_BEEF_0000_0001);
    check("w2_m_wready", 64'(m_wready), 64'h2);
    @(negedge clk);
    m_wvalid = 2'b01;
    #1;
    check("w3_s_wdata", s_wdata, 64'h5555);
    check("w3_m_wready", 64'(m_wready), 64'h1);
    @(negedge clk);
    m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = OKAY; m_bready = 2'b11;
    #1;
    check("b0_m_bvalid", 64'(m_bvalid), 64'h2);
    check("b0_m_bresp", 64'(m_bresp), 64'(OKAY));
    @(negedge clk);
    s_bresp = SLVERR;
    #1;
    check("b1_m_bvalid", 64'(m_bvalid), 64'h1);
    check("b1_m_bresp", 64'(m_bresp), 64'(SLVERR));
    @(negedge clk);
    s_bvalid = 1'b0;
    #1;
    check("b2_proto_err", 64'(proto_err), 64'h0);

    // Two reads still outstanding (m0 then m1); reset drops everything at once.
    @(negedge clk);
    m_arvalid = 2'b11; s_rvalid = 1'b1; m_rready = 2'b11; m_awvalid = 2'b11;
    #1;
    check("prer_m_rvalid", 64'(m_rvalid), 64'h1);
    check("prer_m_arready", 64'(m_arready), 64'h1);
    #2;
    reset_l = 1'b0;
    #1;
    check("ar_m_rvalid", 64'(m_rvalid), 64'h0);
    check("ar_s_rready", 64'(s_rready), 64'h0);
    check("ar_m_arready", 64'(m_arready), 64'h0);
    check("ar_m_awready", 64'(m_awready), 64'h0);
    check("ar_s_arvalid", 64'(s_arvalid), 64'h0);
    @(negedge clk);
    m_arvalid = 2'b00; m_awvalid = 2'b00; s_rvalid = 1'b0;
    reset_l = 1'b1;
    @(negedge clk);
    s_rvalid = 1'b1;
    #1;
    check("emp_m_rvalid", 64'(m_rvalid), 64'h0);
    check("emp_s_rready", 64'(s_rready), 64'h0);
    check("emp_proto_err0", 64'(proto_err), 64'h0);
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    check("r_proto_err", 64'(proto_err), 64'h1);
    reset_l = 1'b0;
    #1;
    check("r_proto_clr", 64'(proto_err), 64'h0);
    @(negedge clk);
    reset_l = 1'b1;

    // Stray write response with nothing outstanding.
    @(negedge clk);
    s_bvalid = 1'b1;
    #1;
    check("bx_s_bready", 64'(s_bready), 64'h0);
    check("bx_m_bvalid", 64'(m_bvalid), 64'h0);
    @(negedge clk);
    s_bvalid = 1'b0;
    #1;
    check("bx_proto_err", 64'(proto_err), 64'h1);
    repeat (3) @(negedge clk);
    #1;
    check("bx_proto_sticky", 64'(proto_err), 64'h1);
    reset_l = 1'b0;
    #1;
    check("bx_proto_clr", 64'(proto_err), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
